pipe_stage_ctrl: RTL and testbench

- Central sequencer for the four RV32I pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Drives each register's `start` input: 1 captures, 0 loads a bubble. Also drives a `hold` that freezes a register.
- Handles program start/fill, load-use stalls, branch/jump redirect flushes, multi-cycle AES stalls, and ecall drain/halt.

---
 rtl/pipe_stage_ctrl_if.sv | 33 +++
 rtl/pipe_stage_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_ctrl_if.sv
// Control/status bundle between pipe_stage_ctrl and the RV32I pipeline datapath.
// master = sequencer side, slave = datapath/environment side.
interface pipe_stage_ctrl_if #(
    parameter int PERF_W = 32
);
    logic              run;
    logic              load_use;
    logic              redirect;
    logic              aes_start;
    logic              aes_done;
    logic              ecall_mem;
    logic              pc_en;
    logic [3:0]        start_o;
    logic [3:0]        hold_o;
    logic [2:0]        state_o;
    logic              busy;
    logic              halted;
    logic              aes_err;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    modport master (
        input  run, load_use, redirect, aes_start, aes_done, ecall_mem,
        output pc_en, start_o, hold_o, state_o, busy, halted, aes_err,
               stall_cnt, flush_cnt
    );

    modport slave (
        output run, load_use, redirect, aes_start, aes_done, ecall_mem,
        input  pc_en, start_o, hold_o, state_o, busy, halted, aes_err,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Sequencer for the four RV32I pipeline registers and the PC: fill, stalls, flushes, AES wait, ecall halt.
// Optional performance counters are enabled with `define PIPE_STAGE_CTRL_PERF_EN.
module pipe_stage_ctrl #(
    parameter int FILL_DEPTH  = 4,
    parameter int AES_TIMEOUT = 64,
    parameter int PERF_W      = 32
) (
    input logic               clk,
    input logic               reset_n,
    pipe_stage_ctrl_if.master bus
);
    localparam int FILL_W = $clog2(FILL_DEPTH + 1);
    localparam int TMR_W  = $clog2(AES_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_RUN      = 3'd2,
        S_AES_WAIT = 3'd3,
        S_DRAIN    = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    state_t            state, next_state;
    logic [FILL_W-1:0] fill_cnt, fill_next;
    logic [TMR_W-1:0]  aes_timer, timer_next;
    logic              aes_err, err_next;
    logic              pc_en;
    logic [3:0]        start_vec;
    logic [3:0]        hold_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            fill_cnt  <= '0;
            aes_timer <= '0;
            aes_err   <= 1'b0;
        end else begin
            state     <= next_state;
            fill_cnt  <= fill_next;
            aes_timer <= timer_next;
            aes_err   <= err_next;
        end
    end

    always_comb begin
        next_state = state;
        fill_next  = fill_cnt;
        timer_next = aes_timer;
        err_next   = aes_err;
        pc_en      = 1'b0;
        start_vec  = 4'b0000;
        hold_vec   = 4'b0000;

        case (state)
            S_IDLE: begin
                if (bus.run) begin
                    next_state = S_FILL;
                    fill_next  = '0;
                    err_next   = 1'b0;
                end
            end

            S_FILL: begin
                pc_en = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    start_vec[k] = (k <= int'(fill_cnt));
                end
                if (fill_cnt == FILL_W'(FILL_DEPTH - 1)) begin
                    next_state = S_RUN;
                end else begin
                    fill_next = fill_cnt + FILL_W'(1);
                end
            end

            // Hazard overrides in strict priority; only ecall and AES leave RUN.
            S_RUN: begin
                pc_en     = 1'b1;
                start_vec = 4'b1111;
                if (bus.ecall_mem) begin
                    next_state = S_DRAIN;
                end else if (bus.redirect) begin
                    start_vec = 4'b1100;
                end else if (bus.aes_start) begin
                    next_state = S_AES_WAIT;
                    pc_en      = 1'b0;
                    hold_vec   = 4'b0011;
                    start_vec  = 4'b1100;
                    timer_next = '0;
                end else if (bus.load_use) begin
                    pc_en     = 1'b0;
                    hold_vec  = 4'b0001;
                    start_vec = 4'b1101;
                end
            end

            // aes_done wins over the timeout when both land in the same cycle.
            S_AES_WAIT: begin
                hold_vec  = 4'b0011;
                start_vec = 4'b1000;
                if (bus.aes_done) begin
                    next_state = S_RUN;
                end else if (aes_timer == TMR_W'(AES_TIMEOUT - 1)) begin
                    next_state = S_RUN;
                    err_next   = 1'b1;
                end else begin
                    timer_next = aes_timer + TMR_W'(1);
                end
            end

            S_DRAIN: begin
                start_vec  = 4'b1000;
                next_state = S_HALT;
            end

            S_HALT: begin
                if (bus.run) begin
                    next_state = S_FILL;
                    fill_next  = '0;
                    err_next   = 1'b0;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    assign bus.pc_en   = pc_en;
    assign bus.start_o = start_vec;
    assign bus.hold_o  = hold_vec;
    assign bus.state_o = state;
    assign bus.busy    = (state == S_FILL) || (state == S_RUN) ||
                         (state == S_AES_WAIT) || (state == S_DRAIN);
    assign bus.halted  = (state == S_HALT);
    assign bus.aes_err = aes_err;

`ifdef PIPE_STAGE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;
    logic              stall_inc;
    logic              flush_inc;
    logic              run_accept;

    // Increment conditions mirror the RUN priority chain so a masked hazard is not counted.
    always_comb begin
        run_accept = bus.run && ((state == S_IDLE) || (state == S_HALT));
        flush_inc  = (state == S_RUN) && !bus.ecall_mem && bus.redirect;
        stall_inc  = (state == S_AES_WAIT) ||
                     ((state == S_RUN) && !bus.ecall_mem && !bus.redirect &&
                      !bus.aes_start && bus.load_use);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (run_accept) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            if (flush_inc) begin
                flush_cnt <= flush_cnt + PERF_W'(1);
            end
        end
    end

    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
`else
    assign bus.stall_cnt = {PERF_W{1'b0}};
    assign bus.flush_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl: directed per-cycle vectors push expected outputs, a negedge monitor checks them.
module tb_pipe_stage_ctrl;
`ifdef PIPE_STAGE_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, RUN = 3'd2,
                           AESW = 3'd3, DRAIN = 3'd4, HALT = 3'd5;

    typedef struct {
        logic        pc;
        logic [3:0]  st;
        logic [3:0]  hd;
        logic [2:0]  state;
        logic        err;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    logic clk;
    logic reset_n;
    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    int   es;
    int   ef;
    bit   finish_req;

    pipe_stage_ctrl_if #(.PERF_W(32)) bus ();

    pipe_stage_ctrl #(
        .FILL_DEPTH (4),
        .AES_TIMEOUT(64),
        .PERF_W     (32)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: drive the inputs just after the edge and queue what the outputs must show.
    task automatic apply_stimulus(input logic run, input logic lu, input logic rd,
                                  input logic as, input logic ad, input logic ec,
                                  input logic pc, input logic [3:0] st, input logic [3:0] hd,
                                  input logic [2:0] state, input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        bus.run       = run;
        bus.load_use  = lu;
        bus.redirect  = rd;
        bus.aes_start = as;
        bus.aes_done  = ad;
        bus.ecall_mem = ec;
        e.pc    = pc;
        e.st    = st;
        e.hd    = hd;
        e.state = state;
        e.err   = err;
        e.stall = PERF_ON ? 32'(es) : 32'd0;
        e.flush = PERF_ON ? 32'(ef) : 32'd0;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output("pc_en",     32'(bus.pc_en),   32'(e.pc));
            check_output("start_o",   32'(bus.start_o), 32'(e.st));
            check_output("hold_o",    32'(bus.hold_o),  32'(e.hd));
            check_output("state_o",   32'(bus.state_o), 32'(e.state));
            check_output("busy",      32'(bus.busy),    32'(e.state >= FILL && e.state <= DRAIN));
            check_output("halted",    32'(bus.halted),  32'(e.state == HALT));
            check_output("aes_err",   32'(bus.aes_err), 32'(e.err));
            check_output("stall_cnt", bus.stall_cnt,    e.stall);
            check_output("flush_cnt", bus.flush_cnt,    e.flush);
        end else if (finish_req) begin
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        n_checks = 0; n_fail = 0; es = 0; ef = 0; finish_req = 1'b0;
        bus.run = 0; bus.load_use = 0; bus.redirect = 0;
        bus.aes_start = 0; bus.aes_done = 0; bus.ecall_mem = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;

        $display("[TB] reset and fill");
        apply_stimulus(0,0,0,0,0,0, 0,4'b0000,4'b0000,IDLE,0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        apply_stimulus(0,0,0,0,0,0, 0,4'b0000,4'b0000,IDLE,0);
        apply_stimulus(1,0,0,0,0,0, 0,4'b0000,4'b0000,IDLE,0);
        apply_stimulus(0,0,0,0,0,0, 1,4'b0001,4'b0000,FILL,0);
        apply_stimulus(0,1,1,1,0,0, 1,4'b0011,4'b0000,FILL,0);
        apply_stimulus(0,0,0,0,0,0, 1,4'b0111,4'b0000,FILL,0);
        apply_stimulus(0,0,0,0,0,0, 1,4'b1111,4'b0000,FILL,0);
        apply_stimulus(0,0,0,0,0,0, 1,4'b1111,4'b0000,RUN,0);

        $display("[TB] load-use and redirect");
        apply_stimulus(0,1,0,0,0,0, 0,4'b1101,4'b0001,RUN,0); es++;
        apply_stimulus(0,0,0,0,0,0, 1,4'b1111,4'b0000,RUN,0);
        apply_stimulus(0,1,1,0,0,0, 1,4'b1100,4'b0000,RUN,0); ef++;
        apply_stimulus(0,0,0,0,0,0, 1,4'b1111,4'b0000,RUN,0);
        apply_stimulus(1,0,0,0,0,0, 1,4'b1111,4'b0000,RUN,0);

        $display("[TB] AES done after 10 cycles");
        apply_stimulus(0,0,0,1,0,0, 0,4'b1100,4'b0011,RUN,0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0,0,0,0,(i == 9),0, 0,4'b1000,4'b0011,AESW,0); es++;
        end
        apply_stimulus(0,0,0,0,0,0, 1,4'b1111,4'b0000,RUN,0);

        $display("[TB] AES done on the timeout cycle");
        apply_stimulus(0,0,0,1,0,0, 0,4'b1100,4'b0011,RUN,0);
        for (int i = 0; i < 64; i++) begin
            apply_stimulus(0,0,0,0,(i == 63),0, 0,4'b1000,4'b0011,AESW,0); es++;
        end
        apply_stimulus(0,0,0,0,0,0, 1,4'b1111,4'b0000,RUN,0);

        $display("[TB] AES timeout");
        apply_stimulus(0,0,0,1,0,0, 0,4'b1100,4'b0011,RUN,0);
        for (int i = 0; i < 64; i++) begin
            apply_stimulus(0,0,0,0,0,0, 0,4'b1000,4'b0011,AESW,0); es++;
        end
        apply_stimulus(0,0,0,0,0,0, 1,4'b1111,4'b0000,RUN,1);
        apply_stimulus(0,0,1,1,0,0, 1,4'b1100,4'b0000,RUN,1); ef++;
        apply_stimulus(0,0,0,0,0,0, 1,4'b1111,4'b0000,RUN,1);

        $display("[TB] ecall drain and halt");
        apply_stimulus(0,0,1,0,0,1, 1,4'b1111,4'b0000,RUN,1);
        apply_stimulus(0,0,0,0,0,0, 0,4'b1000,4'b0000,DRAIN,1);
        apply_stimulus(0,0,0,0,0,0, 0,4'b0000,4'b0000,HALT,1);
        apply_stimulus(1,0,0,0,0,0, 0,4'b0000,4'b0000,HALT,1); es = 0; ef = 0;
        apply_stimulus(0,0,0,0,0,0, 1,4'b0001,4'b0000,FILL,0);
        apply_stimulus(0,0,0,0,0,0, 1,4'b0011,4'b0000,FILL,0);
        apply_stimulus(0,0,0,0,0,0, 1,4'b0111,4'b0000,FILL,0);
        apply_stimulus(0,0,0,0,0,0, 1,4'b1111,4'b0000,FILL,0);
        apply_stimulus(0,0,0,0,0,0, 1,4'b1111,4'b0000,RUN,0);

        $display("[TB] async reset inside AES wait");
        apply_stimulus(0,0,0,1,0,0, 0,4'b1100,4'b0011,RUN,0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0,0,0,0,0,0, 0,4'b1000,4'b0011,AESW,0); es++;
        end
        @(posedge clk);
        #1;
        bus.aes_start = 0;
        bus.aes_done  = 0;
        reset_n       = 1'b0;
        es = 0; ef = 0;
        e.pc = 0; e.st = 4'b0000; e.hd = 4'b0000; e.state = IDLE; e.err = 0;
        e.stall = 32'd0; e.flush = 32'd0;
        sb.push_back(e);
        @(negedge clk);
        #1 finish_req = 1'b1;
    end
endmodule
